// File: rtl/warp_pc_file_if.sv
// Bundle between the fetch-side environment (scheduler, SIMT unit, decode)
// and the per-warp PC file.
//
// Timing contract: there is no back-pressure. Every request field below is a
// per-warp level that the PC file samples on each rising clock edge. A bit
// that is high at an edge is one request for that warp in that cycle; it is
// consumed at that edge whether or not the warp's state lets it take effect.
// All outputs are registered or decoded only from registered state.
interface warp_pc_file_if;
  logic [7:0]  Warp_Init_Valid;
  logic [31:0] Warp_Init_PC;
  logic [7:0]  GRT_raw_1_RR_IF;
  logic [7:0]  GRT_raw_2_RR_IF;
  logic [7:0]  UpdatePC_Qual1_SIMT_IF;
  logic [31:0] Target_PC_Qual1_SIMT;
  logic [7:0]  UpdatePC_Qual2_SIMT_IF;
  logic [31:0] Target_PC_Qual2_SIMT;
  logic [7:0]  UpdatePC_Qual3_ID0_IF;
  logic [31:0] Replay_PC_ID0;
  logic [7:0]  UpdatePC_Qual3_ID1_IF;
  logic [31:0] Replay_PC_ID1;
  logic [7:0]  Warp_Exit_ID;
  logic [31:0] PC0_PC_IF, PC1_PC_IF, PC2_PC_IF, PC3_PC_IF;
  logic [31:0] PC4_PC_IF, PC5_PC_IF, PC6_PC_IF, PC7_PC_IF;
  logic [7:0]  Fetch_Eligible;
  logic [7:0]  Warp_Active;
  logic [7:0]  Pc_Fault;
  // Debug view of the per-warp state machines, two bits per warp.
  logic [15:0] warp_state;

  modport master (
    output Warp_Init_Valid, Warp_Init_PC, GRT_raw_1_RR_IF, GRT_raw_2_RR_IF,
           UpdatePC_Qual1_SIMT_IF, Target_PC_Qual1_SIMT,
           UpdatePC_Qual2_SIMT_IF, Target_PC_Qual2_SIMT,
           UpdatePC_Qual3_ID0_IF, Replay_PC_ID0,
           UpdatePC_Qual3_ID1_IF, Replay_PC_ID1, Warp_Exit_ID,
    input  PC0_PC_IF, PC1_PC_IF, PC2_PC_IF, PC3_PC_IF,
           PC4_PC_IF, PC5_PC_IF, PC6_PC_IF, PC7_PC_IF,
           Fetch_Eligible, Warp_Active, Pc_Fault, warp_state
  );

  modport slave (
    input  Warp_Init_Valid, Warp_Init_PC, GRT_raw_1_RR_IF, GRT_raw_2_RR_IF,
           UpdatePC_Qual1_SIMT_IF, Target_PC_Qual1_SIMT,
           UpdatePC_Qual2_SIMT_IF, Target_PC_Qual2_SIMT,
           UpdatePC_Qual3_ID0_IF, Replay_PC_ID0,
           UpdatePC_Qual3_ID1_IF, Replay_PC_ID1, Warp_Exit_ID,
    output PC0_PC_IF, PC1_PC_IF, PC2_PC_IF, PC3_PC_IF,
           PC4_PC_IF, PC5_PC_IF, PC6_PC_IF, PC7_PC_IF,
           Fetch_Eligible, Warp_Active, Pc_Fault, warp_state
  );
endinterface

// File: rtl/warp_pc_file.sv
// Per-warp program-counter file feeding instruction fetch.
// Each warp keeps a PC stored as fetch address + 4, a 2-bit state
// (IDLE/RUN/HOLD/DONE) and a drain counter that keeps the warp out of fetch
// while stale fetches issued before a redirect or replay drain away.
// Optional build macro PC_BOUNDS_CHECK_EN: any update whose fetch address is
// outside IMEM_BYTES or misaligned parks the warp in DONE with a sticky fault.
module warp_pc_file #(
  parameter int PC_STEP      = 4,
  parameter int DRAIN_CYCLES = 2
`ifdef PC_BOUNDS_CHECK_EN
  , parameter int IMEM_BYTES = 4096
`endif
) (
  input  logic           clk,
  input  logic           rst,
  warp_pc_file_if.slave  bus
);
  localparam logic [1:0]  S_IDLE = 2'd0;
  localparam logic [1:0]  S_RUN  = 2'd1;
  localparam logic [1:0]  S_HOLD = 2'd2;
  localparam logic [1:0]  S_DONE = 2'd3;
  // The counter is loaded with DRAIN_CYCLES-1 so that a HOLD lasting exactly
  // DRAIN_CYCLES cycles ends on the edge where it reads zero.
  localparam logic [1:0]  DRAIN_LOAD = 2'(DRAIN_CYCLES - 1);
  localparam logic [31:0] STEP       = 32'(PC_STEP);
`ifdef PC_BOUNDS_CHECK_EN
  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);
`endif

  logic [31:0] pc_q  [8];
  logic [31:0] pc_d  [8];
  logic [1:0]  st_q  [8];
  logic [1:0]  st_d  [8];
  logic [1:0]  cnt_q [8];
  logic [1:0]  cnt_d [8];
`ifdef PC_BOUNDS_CHECK_EN
  logic [7:0]  fault_q;
  logic [7:0]  fault_d;
`endif

  // Per-warp next state: resolve the highest-priority applicable event.
  always_comb begin
    logic        live;
    logic        upd;
    logic [31:0] cand;
`ifdef PC_BOUNDS_CHECK_EN
    fault_d = fault_q;
`endif
    for (int n = 0; n < 8; n++) begin
      pc_d[n]  = pc_q[n];
      st_d[n]  = st_q[n];
      cnt_d[n] = cnt_q[n];
      live     = (st_q[n] == S_RUN) || (st_q[n] == S_HOLD);
      upd      = 1'b0;
      cand     = pc_q[n];
      if (bus.Warp_Init_Valid[n] && !live) begin
        cand  = bus.Warp_Init_PC + 32'd4;
        st_d[n] = S_RUN;
        upd   = 1'b1;
`ifdef PC_BOUNDS_CHECK_EN
        fault_d[n] = 1'b0;
`endif
      end else if (bus.Warp_Exit_ID[n] && live) begin
        st_d[n] = S_DONE;
      end else if (live && bus.UpdatePC_Qual1_SIMT_IF[n]) begin
        cand = bus.Target_PC_Qual1_SIMT + 32'd4;
        st_d[n] = S_HOLD;  cnt_d[n] = DRAIN_LOAD;  upd = 1'b1;
      end else if (live && bus.UpdatePC_Qual2_SIMT_IF[n]) begin
        cand = bus.Target_PC_Qual2_SIMT + 32'd4;
        st_d[n] = S_HOLD;  cnt_d[n] = DRAIN_LOAD;  upd = 1'b1;
      end else if (live && bus.UpdatePC_Qual3_ID0_IF[n]) begin
        cand = bus.Replay_PC_ID0;
        st_d[n] = S_HOLD;  cnt_d[n] = DRAIN_LOAD;  upd = 1'b1;
      end else if (live && bus.UpdatePC_Qual3_ID1_IF[n]) begin
        cand = bus.Replay_PC_ID1;
        st_d[n] = S_HOLD;  cnt_d[n] = DRAIN_LOAD;  upd = 1'b1;
      end else if ((st_q[n] == S_RUN) &&
                   (bus.GRT_raw_1_RR_IF[n] || bus.GRT_raw_2_RR_IF[n])) begin
        // A warp granted on both ports still advances a single step.
        cand = pc_q[n] + STEP;
        upd  = 1'b1;
      end else if (st_q[n] == S_HOLD) begin
        if (cnt_q[n] == 2'd0) st_d[n] = S_RUN;
        else                  cnt_d[n] = cnt_q[n] - 2'd1;
      end
      if (upd) pc_d[n] = cand;
`ifdef PC_BOUNDS_CHECK_EN
      if (upd && (((cand - 32'd4) >= IMEM_LIMIT) || (cand[1:0] != 2'b00))) begin
        pc_d[n]    = pc_q[n];
        st_d[n]    = S_DONE;
        fault_d[n] = 1'b1;
      end
`endif
    end
  end

  // State registers; reset wins over every request on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < 8; n++) begin
        pc_q[n]  <= 32'd0;
        st_q[n]  <= S_IDLE;
        cnt_q[n] <= 2'd0;
      end
`ifdef PC_BOUNDS_CHECK_EN
      fault_q <= 8'd0;
`endif
    end else begin
      for (int n = 0; n < 8; n++) begin
        pc_q[n]  <= pc_d[n];
        st_q[n]  <= st_d[n];
        cnt_q[n] <= cnt_d[n];
      end
`ifdef PC_BOUNDS_CHECK_EN
      fault_q <= fault_d;
`endif
    end
  end

  // Status flags decoded purely from registered state.
  always_comb begin
    bus.Fetch_Eligible = 8'd0;
    bus.Warp_Active    = 8'd0;
    bus.warp_state     = 16'd0;
    for (int n = 0; n < 8; n++) begin
      bus.Fetch_Eligible[n]    = (st_q[n] == S_RUN);
      bus.Warp_Active[n]       = (st_q[n] == S_RUN) || (st_q[n] == S_HOLD);
      bus.warp_state[2*n +: 2] = st_q[n];
    end
  end

`ifdef PC_BOUNDS_CHECK_EN
  assign bus.Pc_Fault = fault_q;
`else
  assign bus.Pc_Fault = 8'd0;
`endif

  assign bus.PC0_PC_IF = pc_q[0];
  assign bus.PC1_PC_IF = pc_q[1];
  assign bus.PC2_PC_IF = pc_q[2];
  assign bus.PC3_PC_IF = pc_q[3];
  assign bus.PC4_PC_IF = pc_q[4];
  assign bus.PC5_PC_IF = pc_q[5];
  assign bus.PC6_PC_IF = pc_q[6];
  assign bus.PC7_PC_IF = pc_q[7];
endmodule

// File: tb/tb_warp_pc_file.sv
// Testbench for warp_pc_file: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model
// that tracks each warp's PC, mode and remaining ineligible cycles.
module tb_warp_pc_file;
  localparam int D    = 2;
  localparam int STEP = 4;
`ifdef PC_BOUNDS_CHECK_EN
  localparam logic [31:0] IMEM = 32'd4096;
`endif
  localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2, M_DONE = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  bit   cmp_en = 1'b0;

  warp_pc_file_if bus ();
  warp_pc_file dut (.clk(clk), .rst(rst), .bus(bus));

  // Clock and reset
  always #5 clk = ~clk;

  // Model state
  logic [31:0] m_pc   [8];
  int          m_mode [8];
  int          m_left [8];
  logic [7:0]  m_fault;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_pc(input int i);
    case (i)
      0: return bus.PC0_PC_IF;  1: return bus.PC1_PC_IF;
      2: return bus.PC2_PC_IF;  3: return bus.PC3_PC_IF;
      4: return bus.PC4_PC_IF;  5: return bus.PC5_PC_IF;
      6: return bus.PC6_PC_IF;  default: return bus.PC7_PC_IF;
    endcase
  endfunction

  // Behavioural reference: apply the one winning event per warp each edge.
  always @(posedge clk) begin
    logic [31:0] npc;
    int          nmode, nleft;
    logic        nf, upd, live;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        m_pc[i] <= 32'd0; m_mode[i] <= M_IDLE; m_left[i] <= 0;
      end
      m_fault <= 8'd0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        npc = m_pc[i]; nmode = m_mode[i]; nleft = m_left[i];
        nf = m_fault[i]; upd = 1'b0;
        live = (m_mode[i] == M_RUN) || (m_mode[i] == M_HOLD);
        if (bus.Warp_Init_Valid[i] && !live) begin
          npc = bus.Warp_Init_PC + 4; nmode = M_RUN; nf = 1'b0; upd = 1'b1;
        end else if (bus.Warp_Exit_ID[i] && live) begin
          nmode = M_DONE;
        end else if (live && bus.UpdatePC_Qual1_SIMT_IF[i]) begin
          npc = bus.Target_PC_Qual1_SIMT + 4; nmode = M_HOLD; nleft = D; upd = 1'b1;
        end else if (live && bus.UpdatePC_Qual2_SIMT_IF[i]) begin
          npc = bus.Target_PC_Qual2_SIMT + 4; nmode = M_HOLD; nleft = D; upd = 1'b1;
        end else if (live && bus.UpdatePC_Qual3_ID0_IF[i]) begin
          npc = bus.Replay_PC_ID0; nmode = M_HOLD; nleft = D; upd = 1'b1;
        end else if (live && bus.UpdatePC_Qual3_ID1_IF[i]) begin
          npc = bus.Replay_PC_ID1; nmode = M_HOLD; nleft = D; upd = 1'b1;
        end else if (m_mode[i] == M_RUN && (bus.GRT_raw_1_RR_IF[i] || bus.GRT_raw_2_RR_IF[i])) begin
          npc = m_pc[i] + STEP; upd = 1'b1;
        end else if (m_mode[i] == M_HOLD) begin
          nleft = nleft - 1;
          if (nleft == 0) nmode = M_RUN;
        end
`ifdef PC_BOUNDS_CHECK_EN
        if (upd && ((npc - 4) >= IMEM || npc[1:0] != 2'b00)) begin
          npc = m_pc[i]; nmode = M_DONE; nf = 1'b1;
        end
`endif
        m_pc[i] <= npc; m_mode[i] <= nmode; m_left[i] <= nleft; m_fault[i] <= nf;
      end
    end
  end

  // Scoreboard compare on the falling edge, away from the update edge.
  always @(negedge clk) begin
    logic [7:0] e_elig, e_act;
    if (cmp_en) begin
      e_elig = 8'd0; e_act = 8'd0;
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("model_pc%0d", i), dut_pc(i), m_pc[i]);
        e_elig[i] = (m_mode[i] == M_RUN);
        e_act[i]  = (m_mode[i] == M_RUN) || (m_mode[i] == M_HOLD);
      end
      chk("model_elig", {24'd0, bus.Fetch_Eligible}, {24'd0, e_elig});
      chk("model_active", {24'd0, bus.Warp_Active}, {24'd0, e_act});
`ifdef PC_BOUNDS_CHECK_EN
      chk("model_fault", {24'd0, bus.Pc_Fault}, {24'd0, m_fault});
`else
      chk("model_fault", {24'd0, bus.Pc_Fault}, 32'd0);
`endif
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.Warp_Init_Valid = 8'd0;         bus.Warp_Init_PC = 32'd0;
    bus.GRT_raw_1_RR_IF = 8'd0;         bus.GRT_raw_2_RR_IF = 8'd0;
    bus.UpdatePC_Qual1_SIMT_IF = 8'd0;  bus.Target_PC_Qual1_SIMT = 32'd0;
    bus.UpdatePC_Qual2_SIMT_IF = 8'd0;  bus.Target_PC_Qual2_SIMT = 32'd0;
    bus.UpdatePC_Qual3_ID0_IF = 8'd0;   bus.Replay_PC_ID0 = 32'd0;
    bus.UpdatePC_Qual3_ID1_IF = 8'd0;   bus.Replay_PC_ID1 = 32'd0;
    bus.Warp_Exit_ID = 8'd0;
  endtask

  function automatic logic [7:0] rand_mask(input int den);
    logic [7:0] m = 8'd0;
    for (int i = 0; i < 8; i++) m[i] = ($urandom_range(0, den - 1) == 0);
    return m;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a = {18'd0, 12'($urandom_range(0, 1100)), 2'b00};
    if ($urandom_range(0, 63) == 0) a = a + 32'd2;
    return a;
  endfunction

  function automatic logic [7:0] rand_grant();
    int r = $urandom_range(0, 9);
    return (r < 8) ? (8'd1 << r) : 8'd0;
  endfunction

  initial begin
    clear_in();
    rst = 1'b1;
    tick();
    cmp_en = 1'b1;
    tick(); tick();
    chk("reset_pc0", bus.PC0_PC_IF, 32'd0);
    chk("reset_elig", {24'd0, bus.Fetch_Eligible}, 32'd0);
    chk("reset_active", {24'd0, bus.Warp_Active}, 32'd0);
    rst = 1'b0;

    // Start warps 0 and 2 at 0x100.
    bus.Warp_Init_Valid = 8'h05; bus.Warp_Init_PC = 32'h100;
    tick(); clear_in();
    chk("init_pc0", bus.PC0_PC_IF, 32'h104);
    chk("init_pc2", bus.PC2_PC_IF, 32'h104);
    chk("init_pc1", bus.PC1_PC_IF, 32'h0);
    chk("init_elig", {24'd0, bus.Fetch_Eligible}, 32'h05);

    // Three grants to warp0, the first on both ports.
    bus.GRT_raw_1_RR_IF = 8'h01; bus.GRT_raw_2_RR_IF = 8'h01;
    tick();
    chk("dual_grant_pc0", bus.PC0_PC_IF, 32'h108);
    bus.GRT_raw_2_RR_IF = 8'h00;
    tick(); tick(); clear_in();
    chk("grant3_pc0", bus.PC0_PC_IF, 32'h110);

    // Branch redirect beats a same-cycle grant; warp2 held for two cycles.
    bus.UpdatePC_Qual1_SIMT_IF = 8'h04; bus.Target_PC_Qual1_SIMT = 32'h200;
    bus.GRT_raw_1_RR_IF = 8'h04;
    tick();
    bus.UpdatePC_Qual1_SIMT_IF = 8'h00;
    chk("redir_pc2", bus.PC2_PC_IF, 32'h204);
    chk("hold1_elig2", {31'd0, bus.Fetch_Eligible[2]}, 32'd0);
    tick();
    chk("hold2_pc2", bus.PC2_PC_IF, 32'h204);
    chk("hold2_elig2", {31'd0, bus.Fetch_Eligible[2]}, 32'd0);
    tick(); clear_in();
    chk("release_elig2", {31'd0, bus.Fetch_Eligible[2]}, 32'd1);
    chk("release_pc2", bus.PC2_PC_IF, 32'h204);

    // Replay on both decode lanes: lane 0 wins.
    bus.UpdatePC_Qual3_ID0_IF = 8'h01; bus.Replay_PC_ID0 = 32'h108;
    bus.UpdatePC_Qual3_ID1_IF = 8'h01; bus.Replay_PC_ID1 = 32'h10C;
    tick(); clear_in();
    chk("replay_pc0", bus.PC0_PC_IF, 32'h108);
    chk("replay_hold0", {30'd0, bus.Warp_Active[0], bus.Fetch_Eligible[0]}, 32'h2);

    // Exit beats reconvergence while in HOLD; then restart at 0x40.
    bus.Warp_Exit_ID = 8'h01;
    bus.UpdatePC_Qual2_SIMT_IF = 8'h01; bus.Target_PC_Qual2_SIMT = 32'h300;
    tick(); clear_in();
    chk("exit_pc0", bus.PC0_PC_IF, 32'h108);
    chk("exit_active0", {31'd0, bus.Warp_Active[0]}, 32'd0);
    bus.Warp_Init_Valid = 8'h01; bus.Warp_Init_PC = 32'h40;
    tick(); clear_in();
    chk("reinit_pc0", bus.PC0_PC_IF, 32'h44);
    chk("reinit_elig0", {31'd0, bus.Fetch_Eligible[0]}, 32'd1);

`ifdef PC_BOUNDS_CHECK_EN
    bus.Warp_Init_Valid = 8'h02; bus.Warp_Init_PC = 32'h100;
    tick(); clear_in();
    bus.UpdatePC_Qual1_SIMT_IF = 8'h02; bus.Target_PC_Qual1_SIMT = 32'h1000;
    tick(); clear_in();
    chk("bounds_fault1", {31'd0, bus.Pc_Fault[1]}, 32'd1);
    chk("bounds_pc1", bus.PC1_PC_IF, 32'h104);
    chk("bounds_active1", {31'd0, bus.Warp_Active[1]}, 32'd0);
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      bus.Warp_Init_Valid        = rand_mask(24);
      bus.Warp_Init_PC           = rand_addr();
      bus.GRT_raw_1_RR_IF        = rand_grant();
      bus.GRT_raw_2_RR_IF        = ($urandom_range(0, 7) == 0) ? bus.GRT_raw_1_RR_IF : rand_grant();
      bus.UpdatePC_Qual1_SIMT_IF = rand_mask(20);
      bus.Target_PC_Qual1_SIMT   = rand_addr();
      bus.UpdatePC_Qual2_SIMT_IF = rand_mask(20);
      bus.Target_PC_Qual2_SIMT   = rand_addr();
      bus.UpdatePC_Qual3_ID0_IF  = rand_mask(20);
      bus.Replay_PC_ID0          = rand_addr() + 32'd4;
      bus.UpdatePC_Qual3_ID1_IF  = rand_mask(20);
      bus.Replay_PC_ID1          = rand_addr() + 32'd4;
      bus.Warp_Exit_ID           = rand_mask(64);
      tick();
    end
    clear_in();

    // Start every idle/done warp, redirect all, then reset mid-HOLD.
    bus.Warp_Init_Valid = 8'hFF; bus.Warp_Init_PC = 32'h100;
    tick(); clear_in();
    bus.UpdatePC_Qual1_SIMT_IF = 8'hFF; bus.Target_PC_Qual1_SIMT = 32'h80;
    tick(); clear_in();
    chk("all_hold_active", {24'd0, bus.Warp_Active}, 32'hFF);
    chk("all_hold_elig", {24'd0, bus.Fetch_Eligible}, 32'h00);
    rst = 1'b1;
    bus.GRT_raw_1_RR_IF = 8'hFF; bus.Warp_Init_Valid = 8'hFF;
    tick(); clear_in();
    for (int i = 0; i < 8; i++) chk($sformatf("rst_pc%0d", i), dut_pc(i), 32'd0);
    chk("rst_elig", {24'd0, bus.Fetch_Eligible}, 32'd0);
    chk("rst_active", {24'd0, bus.Warp_Active}, 32'd0);
    chk("rst_fault", {24'd0, bus.Pc_Fault}, 32'd0);
    rst = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/warp_pc_file.md
Name: warp_pc_file

Overview:
- Per-warp program-counter stage directly upstream of instruction fetch.
- Holds the PCs of 8 warps and presents them to fetch as PC0..PC7_PC_IF.
- Advances a warp's PC when the round-robin scheduler grants it a fetch port.
- Applies SIMT branch/reconvergence redirects and decode-stage replays.
- Runs a per-warp state machine so a warp is blocked from fetch while stale in-flight fetches drain.

Parameters:
- PC_STEP, 4: byte increment applied per granted fetch.
- DRAIN_CYCLES, 2: cycles a warp is held ineligible after a redirect or replay; legal range 1..3.
- IMEM_BYTES, 4096: instruction memory size in bytes; used only by the optional feature.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- Warp_Init_Valid  in  8  per-warp start request.
- Warp_Init_PC  in  32  start address, shared by all warps started this cycle.
- GRT_raw_1_RR_IF  in  8  one-hot (or zero) grant, fetch port 1.
- GRT_raw_2_RR_IF  in  8  one-hot (or zero) grant, fetch port 2.
- UpdatePC_Qual1_SIMT_IF  in  8  per-warp taken-branch redirect.
- Target_PC_Qual1_SIMT  in  32  branch target address.
- UpdatePC_Qual2_SIMT_IF  in  8  per-warp reconvergence redirect.
- Target_PC_Qual2_SIMT  in  32  reconvergence address.
- UpdatePC_Qual3_ID0_IF  in  8  per-warp replay request, decode lane 0.
- Replay_PC_ID0  in  32  PC+4 of the instruction to replay, lane 0.
- UpdatePC_Qual3_ID1_IF  in  8  per-warp replay request, decode lane 1.
- Replay_PC_ID1  in  32  PC+4 of the instruction to replay, lane 1.
- Warp_Exit_ID  in  8  per-warp EXIT decoded.
- PC0_PC_IF..PC7_PC_IF  out  32 each  registered PC per warp.
- Fetch_Eligible  out  8  warp is in RUN; scheduler may grant it.
- Warp_Active  out  8  warp is in RUN or HOLD.
- Pc_Fault  out  8  sticky per-warp out-of-range flag.

Behaviour:
- Stored PC convention: each PCn holds fetch address + 4. Fetch reads instruction memory at PCn-4.
- Per-warp states: IDLE, RUN, HOLD, DONE. Each warp has its own 2-bit drain counter.
- Reset: all PCs = 0, all states IDLE, counters 0, Fetch_Eligible = 0, Warp_Active = 0, Pc_Fault = 0. Reset overrides every other input on the same edge.
- Event priority per warp per cycle, highest first: init, exit, Qual1, Qual2, Qual3 lane 0, Qual3 lane 1, grant.
- Init:
  - Honoured only in IDLE or DONE: PC <= Warp_Init_PC + 4, state -> RUN.
  - Ignored in RUN and HOLD.
- Exit: from RUN or HOLD -> DONE. PC frozen. Ignored in IDLE and DONE.
- Qual1 / Qual2 redirect:
  - In RUN or HOLD: PC <= target + 4, counter <= DRAIN_CYCLES-1, state -> HOLD.
  - A redirect while already in HOLD reloads both PC and counter.
- Qual3 replay:
  - In RUN or HOLD: PC <= Replay_PC (already +4 form), counter reload, state -> HOLD.
  - Lane 0 wins if both lanes request the same warp.
- Grant:
  - Only in RUN and only when no higher-priority event hits that warp: PC <= PC + PC_STEP.
  - The same warp granted on both ports in one cycle increments once; this is a scheduler error, not flagged.
  - Grants to a warp not in RUN are ignored; PC is unchanged.
- HOLD: counter decrements each cycle with no new redirect or replay. When it is 0 at a clock edge, state -> RUN.
- Latency: redirect in cycle N makes Fetch_Eligible low from N+1 for DRAIN_CYCLES cycles.
- PC arithmetic: 32-bit unsigned, wraps modulo 2^32, no overflow flag.
- All outputs are registered or decoded purely from state; no input-to-output combinational path.

Optional Feature:
- Macro: PC_BOUNDS_CHECK_EN.
- Defined:
  - Any update making the new stored PC-4 >= IMEM_BYTES, or not 4-byte aligned, instead sends the warp to DONE, keeps the old PC, and sets Pc_Fault[n].
  - Pc_Fault clears only on reset or a subsequent init of that warp.
- Undefined: no checks are made and Pc_Fault is tied to 0.

Test Plan:
- Reset, then Warp_Init_Valid=8'h05, Warp_Init_PC=0x100 -> next cycle PC0 = PC2 = 0x104, Fetch_Eligible = 8'h05, other PCs 0.
- Warp0 RUN at 0x104; GRT_raw_1=8'h01 for 3 cycles -> PC0 = 0x110. A simultaneous GRT_raw_2=8'h01 still yields +4 per cycle.
- Warp2 RUN, Qual1[2]=1 with target 0x200, plus grant to warp2 in the same cycle -> PC2 = 0x204, Fetch_Eligible[2] low for exactly 2 cycles. Grants during HOLD leave PC2 unchanged.
- Qual3 on both lanes for warp0, Replay_PC_ID0=0x108, Replay_PC_ID1=0x10C -> PC0 = 0x108, state HOLD.
- Warp0 in HOLD, Warp_Exit_ID=8'h01 and Qual2[0] in the same cycle -> DONE, PC unchanged, Warp_Active[0] = 0. Re-init at 0x40 -> PC0 = 0x44, RUN.
- With PC_BOUNDS_CHECK_EN defined, IMEM_BYTES=4096: redirect warp1 to 0x1000 -> Pc_Fault[1] = 1, DONE, PC1 keeps its old value. Assert rst mid-HOLD -> all outputs return to reset values on the next edge.
